// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the rr_arb4 round-robin arbiter.
package rr_arb4_pkg;

    localparam int unsigned N_REQ          = 4;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned HOLD_LIMIT_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first requester strictly after 'last', wrapping 3->0.
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        any     = |req;
        idx     = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = last + IDX_W'(k);
            if (!w_found && req[w_cand]) begin
                idx     = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Define RR_ARB4_HOLD_LIMIT_EN to force-revoke grants held for HOLD_LIMIT cycles.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned HOLD_LIMIT = HOLD_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (HOLD_LIMIT < 2 || HOLD_LIMIT > 255) begin : g_bad_limit
        $error("rr_arb4: HOLD_LIMIT must be in 2..255");
    end

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx, w_idx_nxt;
    logic             r_gnt_valid;
    logic [IDX_W-1:0] r_last, w_last_nxt;
    logic             w_release;
    logic             w_pick_any;
    logic [IDX_W-1:0] w_pick_idx;

    rr_pick4 u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

`ifdef RR_ARB4_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_LIMIT - 1);
    logic [CNT_W-1:0] r_hold_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_last_nxt  = r_last;
        w_release   = 1'b0;
`ifdef RR_ARB4_HOLD_LIMIT_EN
        w_cnt_nxt     = r_hold_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                w_idx_nxt = '0;
                if (w_pick_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = idx2onehot(w_pick_idx);
                    w_idx_nxt   = w_pick_idx;
`ifdef RR_ARB4_HOLD_LIMIT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            GRANT: begin
                // done wins over a simultaneous hold-limit hit: no timeout pulse then.
                w_release = done || !req[r_gnt_idx];
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_last_nxt  = r_gnt_idx;
                end
`ifdef RR_ARB4_HOLD_LIMIT_EN
                else if (r_hold_cnt == HOLD_MAX) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_last_nxt    = r_gnt_idx;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_last      <= IDX_W'(N_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_last      <= w_last_nxt;
        end
    end

`ifdef RR_ARB4_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus randomized traffic vs a reference model.
module tb_rr_arb4;

    localparam int unsigned HL = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: current owner (-1 when none), last owner, cycles held.
    int   m_owner = -1;
    int   m_last  = 3;
    int   m_held  = 0;
    logic m_to    = 1'b0;

    rr_arb4 #(.HOLD_LIMIT(HL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {gnt, gnt_idx, gnt_valid, timeout};
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        logic [1:0] ix;
        g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        ix = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, ix, (m_owner >= 0), m_to};
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d, input logic rs);
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_held  = 0;
                end
            end
        end else if (d || !r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
`ifdef RR_ARB4_HOLD_LIMIT_EN
        else if (m_held == int'(HL) - 1) begin
            m_last  = m_owner;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
`endif
    endtask

    // Drive inputs (from the falling edge), clock once, advance the model, return to the falling edge.
    task automatic tick(input logic [3:0] r, input logic d, input logic rs);
        req   = r;
        done  = d;
        rst_n = !rs;
        @(posedge clk);
        model_step(r, d, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        tick(4'b1111, 1'b0, 1'b1);
        tick(4'b1111, 1'b0, 1'b1);
        e = 8'h00;
        n_chk++;
        if (obs() !== e) $display("FAIL reset_state obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_rotation();
        logic [7:0] e;
        int seq [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, 1'b0, 1'b0);
            e = {4'(1 << seq[i]), 2'(seq[i]), 1'b1, 1'b0};
            n_chk++;
            if (obs() !== e) $display("FAIL rotation_grant%0d obs=%b exp=%b", i, obs(), e); else n_pass++;
            tick(4'b1111, 1'b1, 1'b0);
            n_chk++;
            if (obs() !== 8'h00) $display("FAIL rotation_idle%0d obs=%b exp=%b", i, obs(), 8'h00); else n_pass++;
        end
    endtask

    task automatic test_last_priority();
        logic [7:0] e;
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b1, 1'b0);
        tick(4'b0101, 1'b0, 1'b0);
        e = {4'b0100, 2'd2, 1'b1, 1'b0};
        n_chk++;
        if (obs() !== e) $display("FAIL last1_pick2 obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0101, 1'b1, 1'b0);
        tick(4'b0101, 1'b0, 1'b0);
        e = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_chk++;
        if (obs() !== e) $display("FAIL last2_wrap0 obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_req_drop();
        logic [7:0] e;
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b1011, 1'b0, 1'b0);
        n_chk++;
        if (obs() !== 8'h00) $display("FAIL reqdrop_release obs=%b exp=%b", obs(), 8'h00); else n_pass++;
        tick(4'b1011, 1'b0, 1'b0);
        e = {4'b1000, 2'd3, 1'b1, 1'b0};
        n_chk++;
        if (obs() !== e) $display("FAIL reqdrop_next3 obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_idle_done_and_hold();
        logic [7:0] e;
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0001, 1'b0, 1'b0);
        e = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_chk++;
        if (obs() !== e) $display("FAIL idle_done_ignored obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b1111, 1'b0, 1'b0);
        n_chk++;
        if (obs() !== e) $display("FAIL grant_stable obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_grant();
        logic [7:0] e;
        tick(4'b1000, 1'b0, 1'b0);
        tick(4'b1000, 1'b0, 1'b1);
        n_chk++;
        if (obs() !== 8'h00) $display("FAIL rst_in_grant obs=%b exp=%b", obs(), 8'h00); else n_pass++;
        tick(4'b1000, 1'b0, 1'b0);
        e = {4'b1000, 2'd3, 1'b1, 1'b0};
        n_chk++;
        if (obs() !== e) $display("FAIL rst_regrant3 obs=%b exp=%b", obs(), e); else n_pass++;
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_hold_limit();
        logic [7:0] e;
        for (int i = 0; i <= int'(HL) + 1; i++) begin
            tick(4'b0010, 1'b0, 1'b0);
`ifdef RR_ARB4_HOLD_LIMIT_EN
            e = (i == int'(HL)) ? {4'b0000, 2'd0, 1'b0, 1'b1} : {4'b0010, 2'd1, 1'b1, 1'b0};
`else
            e = {4'b0010, 2'd1, 1'b1, 1'b0};
`endif
            n_chk++;
            if (obs() !== e) $display("FAIL hold_cycle%0d obs=%b exp=%b", i, obs(), e); else n_pass++;
        end
        tick(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       d;
        logic       rs;
        int         bad_model;
        int         bad_onehot;
        r = 4'b0000;
        bad_model  = 0;
        bad_onehot = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
            d  = ($urandom_range(7, 0) == 0);
            rs = ($urandom_range(63, 0) == 0);
            tick(r, d, rs);
            if (obs() !== model_vec()) begin
                if (bad_model < 5) $display("FAIL random_model cyc=%0d obs=%b exp=%b", i, obs(), model_vec());
                bad_model++;
            end
            if ($countones(gnt) > 1) begin
                if (bad_onehot < 5) $display("FAIL random_onehot cyc=%0d gnt=%b exp=at most one bit", i, gnt);
                bad_onehot++;
            end
        end
        n_chk++;
        if (bad_model == 0) n_pass++; else $display("FAIL random_model_total bad=%0d exp=0", bad_model);
        n_chk++;
        if (bad_onehot == 0) n_pass++; else $display("FAIL random_onehot_total bad=%0d exp=0", bad_onehot);
    endtask

    initial begin
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_rotation();
        test_last_priority();
        test_req_drop();
        test_idle_done_and_hold();
        test_reset_in_grant();
        test_hold_limit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
